seq_controller: RTL and testbench
=================================

SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 64'h0, PC loaded on reset; IMEM_SIZE, default 1024, instruction memory size in bytes (used only under REQ-030).
REQ-002 Port clk SHALL be: input, 1 bit, the only clock; all state updates on posedge clk.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high.
REQ-004 Port start SHALL be: input, 1 bit, leave IDLE and begin execution.
REQ-005 Port instr SHALL be: input, 80 bits, fetched bytes; byte k at bits [8k+7:8k], byte0 = {icode,ifun}.
REQ-006 Port instr_valid SHALL be: input, 1 bit, instr is valid for the current pc.
REQ-007 Port stall SHALL be: input, 1 bit, freeze the FSM in its current state.
REQ-008 Port cnd SHALL be: input, 1 bit, branch condition from execute.
REQ-009 Port valM SHALL be: input, 64 bits, value read from data memory (return address for ret).
REQ-010 Port pc SHALL be: output, 64 bits, address of the current instruction.
REQ-011 Port fetch_req SHALL be: output, 1 bit, request instruction bytes at pc.
REQ-012 Port stage SHALL be: output, 3 bits, FSM state encoding.
REQ-013 Ports icode, ifun, rA, rB SHALL be: outputs, 4 bits each, decoded fields.
REQ-014 Ports valC, valP SHALL be: outputs, 64 bits each, constant word and fall-through PC.
REQ-015 Port stat SHALL be: output, 3 bits; 1=AOK, 2=HLT, 3=ADR, 4=INS.

Function
REQ-016 States SHALL be encoded: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
REQ-017 IDLE SHALL move to FETCH on start=1; start SHALL be ignored in all other states.
REQ-018 fetch_req SHALL be 1 exactly while in FETCH.
REQ-019 In FETCH with stall=0 and instr_valid=1, the block SHALL latch icode/ifun/rA/rB/valC/valP and advance in the same cycle; with instr_valid=0 it SHALL remain in FETCH.
REQ-020 Instruction length SHALL be: 1 for icode 0, 1, 9; 2 for 2, 6, A, B; 10 for 3, 4, 5; 9 for 7, 8; any other icode SHALL be invalid.
REQ-021 rA/rB SHALL come from byte1 when length is 2 or 10, else both 4'hF.
REQ-022 valC SHALL be bytes 2..9 (little-endian) for icode 3, 4, 5; bytes 1..8 for icode 7, 8; else 0.
REQ-023 valP SHALL be pc + length, modulo 2^64 (wrap permitted).
REQ-024 An invalid icode in FETCH SHALL set stat=INS and go to HALT; icode 0 SHALL set stat=HLT and go to HALT; pc SHALL be unchanged in both cases.
REQ-025 DECODE to EXECUTE to MEMORY to WRITEBACK to PCUPD SHALL each take one cycle when stall=0.
REQ-026 stall=1 SHALL hold state and all registered outputs in any state except IDLE and HALT; instr_valid SHALL be ignored while stall=1.
REQ-027 In PCUPD, pc SHALL load: valC if icode=8, or if icode=7 and cnd=1; valM (sampled in PCUPD) if icode=9; else valP. The FSM SHALL then return to FETCH.
REQ-028 HALT SHALL be exited only by reset; outputs SHALL hold their values in HALT.

Reset
REQ-029 reset=1 SHALL, from any state including mid-instruction: set state=IDLE, pc=RESET_PC, stat=AOK, fetch_req=0, icode=ifun=0, rA=rB=4'hF, valC=0, valP=0; reset SHALL override start and stall.

Configuration
REQ-030 With macro SEQ_ADDR_CHECK_EN defined, FETCH SHALL compare pc + length against IMEM_SIZE; if greater, it SHALL set stat=ADR and go to HALT with pc unchanged. Without the macro, there SHALL be no address check, and stat SHALL never be ADR.

Verification
REQ-031 Reset, then start, then nop (instr byte0=8'h10, instr_valid=1) -> pc 0 to 1 after 6 cycles from FETCH; stat=1.
REQ-032 irmovq at pc=0x10 (8'h30, 8'hF2, valC=64'h1234) -> rA=F, rB=2, valC=64'h1234, valP=0x1A, next pc=0x1A.
REQ-033 jne at pc=0x20 with dest 0x100: with cnd=0 -> pc=0x29; with cnd=1 -> pc=0x100; ret with valM=0x40 -> pc=0x40.
REQ-034 byte0=8'hC0 -> stat=4, stage=7, pc unchanged; halt byte 8'h00 -> stat=2; in both cases start has no effect until reset.
REQ-035 stall=1 for 3 cycles in EXECUTE -> stage stays 3 and pc stays constant; reset asserted in MEMORY -> next cycle stage=0, pc=RESET_PC.
REQ-036 With SEQ_ADDR_CHECK_EN defined and IMEM_SIZE=1024, irmovq at pc=1020 -> stat=3, HALT; without the macro, the same stimulus -> pc=1030.

Source files
------------

// File: rtl/seq_controller.sv
// Sequential Y86-style fetch/decode/execute controller: one instruction walks
// FETCH..PCUPD, faults and halts park in HALT. Optional macro: SEQ_ADDR_CHECK_EN.
module seq_controller #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [79:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        cnd,
  input  logic [63:0] valM,
  output logic [63:0] pc,
  output logic        fetch_req,
  output logic [2:0]  stage,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        fetch_req_q;
  logic [3:0]  icode_q, ifun_q, rA_q, rB_q;
  logic [63:0] valC_q, valP_q;
  logic [2:0]  stat_q;

  // Decode of the bytes currently on instr, relative to pc_q.
  logic [3:0]  f_icode, f_ifun;
  logic [3:0]  len_d;
  logic        ins_ok_d;
  logic        adr_err_d;
  logic [3:0]  rA_d, rB_d;
  logic [63:0] valC_d, valP_d;

  assign f_icode = instr[7:4];
  assign f_ifun  = instr[3:0];

  always_comb begin
    len_d    = 4'd0;
    ins_ok_d = 1'b1;
    case (f_icode)
      4'h0, 4'h1, 4'h9:       len_d = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_d = 4'd2;
      4'h3, 4'h4, 4'h5:       len_d = 4'd10;
      4'h7, 4'h8:             len_d = 4'd9;
      default:                ins_ok_d = 1'b0;
    endcase
  end

  always_comb begin
    valC_d = 64'h0;
    case (f_icode)
      4'h3, 4'h4, 4'h5: valC_d = instr[79:16];
      4'h7, 4'h8:       valC_d = instr[71:8];
      default:          valC_d = 64'h0;
    endcase
  end

  assign rA_d   = (len_d == 4'd2 || len_d == 4'd10) ? instr[15:12] : 4'hF;
  assign rB_d   = (len_d == 4'd2 || len_d == 4'd10) ? instr[11:8]  : 4'hF;
  assign valP_d = pc_q + {60'h0, len_d};

`ifdef SEQ_ADDR_CHECK_EN
  // Widened so a pc near the top of the address space cannot wrap past the check.
  logic [64:0] end_addr;
  assign end_addr  = {1'b0, pc_q} + {61'h0, len_d};
  assign adr_err_d = (end_addr > 65'(IMEM_SIZE));
`else
  assign adr_err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      icode_q     <= 4'h0;
      ifun_q      <= 4'h0;
      rA_q        <= 4'hF;
      rB_q        <= 4'hF;
      valC_q      <= 64'h0;
      valP_q      <= 64'h0;
      stat_q      <= STAT_AOK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_FETCH;
            fetch_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!stall && instr_valid) begin
            icode_q     <= f_icode;
            ifun_q      <= f_ifun;
            rA_q        <= rA_d;
            rB_q        <= rB_d;
            valC_q      <= valC_d;
            valP_q      <= valP_d;
            fetch_req_q <= 1'b0;
            if (!ins_ok_d) begin
              stat_q  <= STAT_INS;
              state_q <= S_HALT;
            end else if (adr_err_d) begin
              stat_q  <= STAT_ADR;
              state_q <= S_HALT;
            end else if (f_icode == 4'h0) begin
              stat_q  <= STAT_HLT;
              state_q <= S_HALT;
            end else begin
              state_q <= S_DECODE;
            end
          end
        end
        S_DECODE:    if (!stall) state_q <= S_EXECUTE;
        S_EXECUTE:   if (!stall) state_q <= S_MEMORY;
        S_MEMORY:    if (!stall) state_q <= S_WRITEBACK;
        S_WRITEBACK: if (!stall) state_q <= S_PCUPD;
        S_PCUPD: begin
          if (!stall) begin
            if (icode_q == 4'h8 || (icode_q == 4'h7 && cnd)) pc_q <= valC_q;
            else if (icode_q == 4'h9)                       pc_q <= valM;
            else                                            pc_q <= valP_q;
            state_q     <= S_FETCH;
            fetch_req_q <= 1'b1;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc        = pc_q;
  assign fetch_req = fetch_req_q;
  assign stage     = state_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = rA_q;
  assign rB        = rB_q;
  assign valC      = valC_q;
  assign valP      = valP_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed corner sequences, a vector
// table, and randomized instruction streams against a reference model.
module tb_seq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, instr_valid = 1'b0, stall = 1'b0, cnd = 1'b0;
  logic [79:0] instr = 80'h0;
  logic [63:0] valM = 64'h0;
  logic [63:0] pc, valC, valP;
  logic        fetch_req;
  logic [2:0]  stage, stat;
  logic [3:0]  icode, ifun, rA, rB;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  seq_controller dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .cnd(cnd), .valM(valM),
    .pc(pc), .fetch_req(fetch_req), .stage(stage), .icode(icode),
    .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat(stat)
  );

  always #5 clk = ~clk;

  // Instruction lengths indexed by icode; 0 marks an invalid icode.
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};

  typedef struct {
    logic [63:0] start_pc;
    logic [79:0] ins;
    logic        c;
    logic [63:0] vm;
    logic [63:0] e_pc;
    logic [3:0]  e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; instr_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH until back in FETCH or in HALT.
  task automatic run_instr(input logic [79:0] ins, input logic c, input logic [63:0] vm,
                           input bit rnd, output bit ok);
    bit         left;
    logic [2:0] prev_stage;
    logic [63:0] prev_pc;
    left = 1'b0; ok = 1'b0;
    instr = ins; cnd = c; valM = vm;
    for (int n = 0; n < 300 && !ok; n++) begin
      stall       = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      instr_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      prev_stage  = stage;
      prev_pc     = pc;
      tick();
      if (rnd && (stall || (prev_stage == 3'd1 && !instr_valid)) &&
          prev_stage != 3'd0 && prev_stage != 3'd7) begin
        check("hold_stage", stage, prev_stage);
        check("hold_pc", pc, prev_pc);
      end
      if (stage != 3'd1) left = 1'b1;
      if (stage == 3'd7 || (left && stage == 3'd1)) ok = 1'b1;
    end
    stall = 1'b0; instr_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL run_instr_timeout: stage %0d never completed", stage);
    end
  endtask

  // Reset, start, and steer pc to dest with a call at RESET_PC (0).
  task automatic goto_pc(input logic [63:0] dest);
    bit ok;
    do_reset();
    start_pulse();
    if (dest != 64'h0) run_instr({8'h00, dest, 8'h80}, 1'b0, 64'h0, 1'b0, ok);
  endtask

  function automatic vec_t mk(input logic [63:0] sp, input logic [79:0] ins, input logic c,
                              input logic [63:0] vm, input logic [63:0] epc, input logic [3:0] era,
                              input logic [3:0] erb, input logic [63:0] evc, input logic [63:0] evp);
    vec_t v;
    v.start_pc = sp; v.ins = ins; v.c = c; v.vm = vm; v.e_pc = epc;
    v.e_ra = era; v.e_rb = erb; v.e_valc = evc; v.e_valp = evp;
    return v;
  endfunction

  function automatic logic [63:0] m_valc(input logic [79:0] ins);
    case (ins[7:4])
      4'h3, 4'h4, 4'h5: return ins[79:16];
      4'h7, 4'h8:       return ins[71:8];
      default:          return 64'h0;
    endcase
  endfunction

  initial begin
    bit ok;
    logic [63:0] model_pc, e_pc, e_valc, e_valp, got_pc;
    logic [79:0] ins;
    logic [3:0]  ic, e_ra, e_rb;
    logic        c;
    logic [63:0] vm;
    int          len;

    // Reset state and the nop walk through all six stages.
    do_reset();
    check("rst_stage", stage, 3'd0);
    check("rst_pc", pc, 64'h0);
    check("rst_stat", stat, 3'd1);
    check("rst_fetch_req", fetch_req, 1'b0);
    check("rst_icode", icode, 4'h0);
    check("rst_ra", rA, 4'hF);
    check("rst_rb", rB, 4'hF);
    check("rst_valc", valC, 64'h0);
    check("rst_valp", valP, 64'h0);
    tick();
    check("idle_no_start", stage, 3'd0);
    start_pulse();
    check("start_stage", stage, 3'd1);
    check("start_fetch_req", fetch_req, 1'b1);
    instr = {72'h0, 8'h10}; instr_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      instr_valid = 1'b0;
      if (i == 1) begin
        check("nop_decode", stage, 3'd2);
        check("nop_fetch_req_low", fetch_req, 1'b0);
        start = 1'b1;
      end
      if (i == 2) begin
        start = 1'b0;
        check("nop_execute", stage, 3'd3);
      end
      if (i == 5) begin
        check("nop_pcupd", stage, 3'd6);
        check("nop_pc_before", pc, 64'h0);
      end
      if (i == 6) begin
        check("nop_pc_after", pc, 64'h1);
        check("nop_refetch", stage, 3'd1);
        check("nop_fetch_req", fetch_req, 1'b1);
        check("nop_stat", stat, 3'd1);
      end
    end

    // Vector table.
    vecs.push_back(mk(64'h10, {64'h1234, 8'hF2, 8'h30}, 0, 0, 64'h1A, 4'hF, 4'h2, 64'h1234, 64'h1A));
    vecs.push_back(mk(64'h20, {8'h0, 64'h100, 8'h74}, 0, 0, 64'h29, 4'hF, 4'hF, 64'h100, 64'h29));
    vecs.push_back(mk(64'h20, {8'h0, 64'h100, 8'h74}, 1, 0, 64'h100, 4'hF, 4'hF, 64'h100, 64'h29));
    vecs.push_back(mk(64'h100, {72'h0, 8'h90}, 0, 64'h40, 64'h40, 4'hF, 4'hF, 64'h0, 64'h101));
    vecs.push_back(mk(64'h40, {64'h0, 8'h35, 8'h20}, 1, 0, 64'h42, 4'h3, 4'h5, 64'h0, 64'h42));
    vecs.push_back(mk(64'h50, {8'h0, 64'h2000, 8'h80}, 0, 0, 64'h2000, 4'hF, 4'hF, 64'h2000, 64'h59));
    vecs.push_back(mk(64'h8, {64'hDEADBEEF0BADF00D, 8'h67, 8'h50}, 0, 0, 64'h12, 4'h6, 4'h7,
                      64'hDEADBEEF0BADF00D, 64'h12));
    vecs.push_back(mk(64'h3, {64'h0, 8'h8F, 8'hA0}, 0, 0, 64'h5, 4'h8, 4'hF, 64'h0, 64'h5));
    vecs.push_back(mk(64'h200, {64'h0, 8'h12, 8'h61}, 0, 0, 64'h202, 4'h1, 4'h2, 64'h0, 64'h202));
    vecs.push_back(mk(64'h77, {72'hFFFFFFFFFFFFFFFFFF, 8'h10}, 0, 0, 64'h78, 4'hF, 4'hF, 64'h0, 64'h78));
    vecs.push_back(mk(64'h30, {8'h0, 64'h300, 8'h70}, 1, 0, 64'h300, 4'hF, 4'hF, 64'h300, 64'h39));
`ifndef SEQ_ADDR_CHECK_EN
    vecs.push_back(mk(64'hFFFFFFFFFFFFFFFF, {72'h0, 8'h10}, 0, 0, 64'h0, 4'hF, 4'hF, 64'h0, 64'h0));
    vecs.push_back(mk(64'hFFFFFFFFFFFFFFFC, {64'h7, 8'hF1, 8'h30}, 0, 0, 64'h6, 4'hF, 4'h1, 64'h7, 64'h6));
`endif
    foreach (vecs[k]) begin
      goto_pc(vecs[k].start_pc);
      run_instr(vecs[k].ins, vecs[k].c, vecs[k].vm, 1'b0, ok);
      check($sformatf("vec%0d_pc", k), pc, vecs[k].e_pc);
      check($sformatf("vec%0d_ra", k), rA, vecs[k].e_ra);
      check($sformatf("vec%0d_rb", k), rB, vecs[k].e_rb);
      check($sformatf("vec%0d_valc", k), valC, vecs[k].e_valc);
      check($sformatf("vec%0d_valp", k), valP, vecs[k].e_valp);
      check($sformatf("vec%0d_stat", k), stat, 3'd1);
      check($sformatf("vec%0d_stage", k), stage, 3'd1);
    end

    // Invalid icode and halt: parked in HALT until reset.
    goto_pc(64'h30);
    instr = {72'h0, 8'hC0}; instr_valid = 1'b1;
    tick();
    check("ins_stage", stage, 3'd7);
    check("ins_stat", stat, 3'd4);
    check("ins_pc", pc, 64'h30);
    start = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0; stall = 1'b0; instr_valid = 1'b0;
    check("ins_hold_stage", stage, 3'd7);
    check("ins_hold_stat", stat, 3'd4);
    check("ins_hold_pc", pc, 64'h30);
    do_reset();
    check("ins_reset_stage", stage, 3'd0);
    check("ins_reset_stat", stat, 3'd1);
    goto_pc(64'h44);
    run_instr({72'h0, 8'h00}, 1'b0, 64'h0, 1'b0, ok);
    check("hlt_stage", stage, 3'd7);
    check("hlt_stat", stat, 3'd2);
    check("hlt_pc", pc, 64'h44);
    start_pulse();
    tick();
    check("hlt_start_ignored", stage, 3'd7);

    // Stall in FETCH and EXECUTE.
    goto_pc(64'h0);
    instr = {72'h0, 8'h10}; instr_valid = 1'b1; stall = 1'b1;
    tick(); tick();
    check("stall_fetch_stage", stage, 3'd1);
    stall = 1'b0;
    tick(); tick();
    instr_valid = 1'b0;
    check("stall_exec_enter", stage, 3'd3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_exec_stage", stage, 3'd3);
      check("stall_exec_pc", pc, 64'h0);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stall_release_pc", pc, 64'h1);
    check("stall_release_stage", stage, 3'd1);

    // Reset mid-instruction, overriding start and stall.
    goto_pc(64'h60);
    instr = {64'h55, 8'hF3, 8'h30}; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    check("mid_memory", stage, 3'd4);
    check("mid_valc", valC, 64'h55);
    reset = 1'b1; start = 1'b1; stall = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; stall = 1'b0;
    check("mid_rst_stage", stage, 3'd0);
    check("mid_rst_pc", pc, 64'h0);
    check("mid_rst_ra", rA, 4'hF);
    check("mid_rst_rb", rB, 4'hF);
    check("mid_rst_icode", icode, 4'h0);
    check("mid_rst_valc", valC, 64'h0);
    check("mid_rst_valp", valP, 64'h0);
    check("mid_rst_fetch_req", fetch_req, 1'b0);

    // Top-of-memory fetch.
    goto_pc(64'd1020);
    run_instr({64'h5, 8'hF2, 8'h30}, 1'b0, 64'h0, 1'b0, ok);
`ifdef SEQ_ADDR_CHECK_EN
    check("adr_stage", stage, 3'd7);
    check("adr_stat", stat, 3'd3);
    check("adr_pc", pc, 64'd1020);
`else
    check("noadr_pc", pc, 64'd1030);
    check("noadr_stat", stat, 3'd1);
    check("noadr_stage", stage, 3'd1);
`endif

    // Randomized stream against the reference model.
    goto_pc(64'h0);
    model_pc = 64'h0;
    for (int t = 0; t < 150; t++) begin
      ins = {16'($urandom()), $urandom(), $urandom()};
      ic  = (model_pc >= 64'd900) ? 4'h8 : 4'($urandom_range(1, 11));
      ins[7:0] = {ic, 4'($urandom_range(0, 15))};
      if (ic == 4'h7 || ic == 4'h8) ins[71:8] = 64'($urandom_range(0, 511));
      c  = 1'($urandom_range(0, 1));
      vm = 64'($urandom_range(0, 511));
      len    = len_tab[ic];
      e_valc = m_valc(ins);
      e_valp = model_pc + 64'(len);
      e_ra   = (len == 2 || len == 10) ? ins[15:12] : 4'hF;
      e_rb   = (len == 2 || len == 10) ? ins[11:8]  : 4'hF;
      if (ic == 4'h8 || (ic == 4'h7 && c)) e_pc = e_valc;
      else if (ic == 4'h9)                e_pc = vm;
      else                                e_pc = e_valp;
      exp_q.push_back(e_pc);
      run_instr(ins, c, vm, 1'b1, ok);
      got_pc = exp_q.pop_front();
      check("rnd_pc", pc, got_pc);
      check("rnd_icode", icode, ins[7:4]);
      check("rnd_ifun", ifun, ins[3:0]);
      check("rnd_ra", rA, e_ra);
      check("rnd_rb", rB, e_rb);
      check("rnd_valc", valC, e_valc);
      check("rnd_valp", valP, e_valp);
      check("rnd_stat", stat, 3'd1);
      model_pc = e_pc;
      if (!ok) break;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
